prefetch_refill_engine: RTL and testbench

//   Refill stage directly upstream of the prefetching cache. Accepts demand-miss requests from the cache.

---
 rtl/prefetch_refill_engine.sv | 186 ++++++++++++++++++
 tb/tb_prefetch_refill_engine.sv | 344 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefetch_refill_engine.sv
// rtl/prefetch_refill_engine.sv - demand-miss refill engine with next-block prefetch queue
module prefetch_refill_engine #(
  parameter int ADDR_WIDTH = 8,
  parameter int BLOCK_SIZE = 4,
  parameter int PF_DEPTH   = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  miss_valid,
  input  logic [ADDR_WIDTH-1:0] miss_addr,
  output logic                  miss_ready,
  input  logic                  pf_enable,
  output logic                  mem_req_valid,
  output logic [ADDR_WIDTH-1:0] mem_req_addr,
  input  logic                  mem_req_ready,
  input  logic                  mem_rsp_valid,
  input  logic [31:0]           mem_rsp_data,
  output logic                  fill_valid,
  output logic [ADDR_WIDTH-1:0] fill_addr,
  output logic [31:0]           fill_data,
  output logic                  fill_prefetch,
  output logic                  busy,
  output logic [7:0]            pf_drop_count
);

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~ADDR_WIDTH'(BLOCK_SIZE - 1);
  localparam logic [ADDR_WIDTH-1:0] BLK_STEP = ADDR_WIDTH'(BLOCK_SIZE);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_FILL = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  kind_q, kind_d;
  logic [31:0]           data_q, data_d;
  logic [7:0]            drop_q, drop_d;

  // Prefetch queue is kept compacted: valid bits form a thermometer from
  // entry 0 (oldest) upward, so removal anywhere shifts younger entries down.
  logic [ADDR_WIDTH-1:0] fifo_q  [PF_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_rm [PF_DEPTH];
  logic [ADDR_WIDTH-1:0] fifo_d  [PF_DEPTH];
  logic [PF_DEPTH-1:0]   vld_q, vld_rm, vld_d;

  logic [ADDR_WIDTH-1:0] miss_base;
  logic [ADDR_WIDTH-1:0] pf_addr;
  logic                  accept;
  logic                  pop;
  logic                  rm_shift;
  logic                  rm_hit;
  logic                  pf_dup;
  logic                  pf_placed;

  assign miss_base = miss_addr & BLK_MASK;
  assign pf_addr   = miss_base + BLK_STEP;
  assign accept    = (state_q == ST_IDLE) && miss_valid;
  assign pop       = (state_q == ST_IDLE) && !miss_valid && vld_q[0];

  // Next-state and transaction capture: demand beats prefetch in IDLE.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    kind_d  = kind_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          addr_d  = miss_base;
          kind_d  = 1'b0;
          state_d = ST_REQ;
        end else if (pop) begin
          addr_d  = fifo_q[0];
          kind_d  = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (mem_req_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_rsp_valid) begin
          data_d  = mem_rsp_data;
          state_d = ST_FILL;
        end
      end
      ST_FILL: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Removal: a pop takes entry 0; an accepted miss promotes its matching entry.
  always_comb begin
    rm_shift = 1'b0;
    rm_hit   = 1'b0;
    fifo_rm  = fifo_q;
    vld_rm   = vld_q;
    for (int i = 0; i < PF_DEPTH; i++) begin
      rm_hit   = accept ? (vld_q[i] && (fifo_q[i] == miss_base)) : (pop && (i == 0));
      rm_shift = rm_shift | rm_hit;
      if (rm_shift) begin
        if (i < PF_DEPTH - 1) begin
          fifo_rm[i] = fifo_q[(i + 1 < PF_DEPTH) ? i + 1 : i];
          vld_rm[i]  = vld_q[(i + 1 < PF_DEPTH) ? i + 1 : i];
        end else begin
          vld_rm[i]  = 1'b0;
        end
      end
    end
  end

  // Push of the next block on an accepted miss, after any promotion removal.
  always_comb begin
    fifo_d    = fifo_rm;
    vld_d     = vld_rm;
    drop_d    = drop_q;
    pf_dup    = 1'b0;
    pf_placed = 1'b0;
    for (int i = 0; i < PF_DEPTH; i++) begin
      if (vld_rm[i] && (fifo_rm[i] == pf_addr)) begin
        pf_dup = 1'b1;
      end
    end
    if (accept && pf_enable && !pf_dup) begin
      if (vld_rm[PF_DEPTH-1]) begin
        if (drop_q != 8'hFF) begin
          drop_d = drop_q + 8'd1;
        end
      end else begin
        for (int i = 0; i < PF_DEPTH; i++) begin
          if (!vld_rm[i] && !pf_placed) begin
            fifo_d[i] = pf_addr;
            vld_d[i]  = 1'b1;
            pf_placed = 1'b1;
          end
        end
      end
    end
  end

  // State, transaction and queue registers; reset abandons any transaction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      kind_q  <= 1'b0;
      data_q  <= '0;
      drop_q  <= '0;
      vld_q   <= '0;
      for (int i = 0; i < PF_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      kind_q  <= kind_d;
      data_q  <= data_d;
      drop_q  <= drop_d;
      vld_q   <= vld_d;
      for (int i = 0; i < PF_DEPTH; i++) begin
        fifo_q[i] <= fifo_d[i];
      end
    end
  end

  // miss_ready is gated by reset so every output reads 0 while reset is held.
  assign miss_ready    = reset_n && (state_q == ST_IDLE);
  assign mem_req_valid = (state_q == ST_REQ);
  assign mem_req_addr  = mem_req_valid ? addr_q : '0;
  assign fill_valid    = (state_q == ST_FILL);
  assign fill_addr     = fill_valid ? addr_q : '0;
  assign fill_data     = fill_valid ? data_q : '0;
  assign fill_prefetch = fill_valid && kind_q;
  assign busy          = (state_q != ST_IDLE) || vld_q[0];
  assign pf_drop_count = drop_q;

endmodule

// File: tb/tb_prefetch_refill_engine.sv
// tb/tb_prefetch_refill_engine.sv - self-checking bench for prefetch_refill_engine
module tb_prefetch_refill_engine;

  localparam int AW    = 8;
  localparam int BS    = 4;
  localparam int DEPTH = 2;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          miss_valid = 1'b0;
  logic [AW-1:0] miss_addr = '0;
  logic          miss_ready;
  logic          pf_enable = 1'b0;
  logic          mem_req_valid;
  logic [AW-1:0] mem_req_addr;
  logic          mem_req_ready = 1'b0;
  logic          mem_rsp_valid = 1'b0;
  logic [31:0]   mem_rsp_data = '0;
  logic          fill_valid;
  logic [AW-1:0] fill_addr;
  logic [31:0]   fill_data;
  logic          fill_prefetch;
  logic          busy;
  logic [7:0]    pf_drop_count;

  always #5 clk = ~clk;

  prefetch_refill_engine #(
    .ADDR_WIDTH(AW),
    .BLOCK_SIZE(BS),
    .PF_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .miss_valid   (miss_valid),
    .miss_addr    (miss_addr),
    .miss_ready   (miss_ready),
    .pf_enable    (pf_enable),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr (mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid),
    .mem_rsp_data (mem_rsp_data),
    .fill_valid   (fill_valid),
    .fill_addr    (fill_addr),
    .fill_data    (fill_data),
    .fill_prefetch(fill_prefetch),
    .busy         (busy),
    .pf_drop_count(pf_drop_count)
  );

  int total = 0;
  int bad   = 0;

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Transaction-level reference: one pending block fetch plus an ordered list of queued prefetches.
  bit            m_active;
  bit            m_req_sent;
  bit            m_rsp_got;
  bit            m_pf;
  bit            m_accepted;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_data;
  logic [AW-1:0] m_q[$];
  int            m_drop;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    logic          p;
  } fill_t;

  logic [AW-1:0] req_log[$];
  fill_t         fill_log[$];
  logic [31:0]   rsp_word = '0;

  function automatic logic [AW-1:0] blk(input logic [AW-1:0] a);
    return a & ~(AW'(BS - 1));
  endfunction

  task automatic model_reset();
    m_active   = 0;
    m_req_sent = 0;
    m_rsp_got  = 0;
    m_pf       = 0;
    m_accepted = 0;
    m_addr     = '0;
    m_data     = '0;
    m_q.delete();
    m_drop     = 0;
  endtask

  task automatic model_step();
    logic [AW-1:0] base;
    logic [AW-1:0] pa;
    bit            found;
    m_accepted = 0;
    if (!m_active) begin
      if (miss_valid) begin
        base = blk(miss_addr);
        for (int i = 0; i < m_q.size(); i++) begin
          if (m_q[i] == base) begin
            m_q.delete(i);
            break;
          end
        end
        if (pf_enable) begin
          pa    = base + AW'(BS);
          found = 0;
          foreach (m_q[i]) if (m_q[i] == pa) found = 1;
          if (!found) begin
            if (m_q.size() >= DEPTH) m_drop = (m_drop < 255) ? m_drop + 1 : 255;
            else m_q.push_back(pa);
          end
        end
        m_accepted = 1;
        m_active   = 1;
        m_addr     = base;
        m_pf       = 0;
        m_req_sent = 0;
        m_rsp_got  = 0;
      end else if (m_q.size() > 0) begin
        m_addr     = m_q.pop_front();
        m_pf       = 1;
        m_active   = 1;
        m_req_sent = 0;
        m_rsp_got  = 0;
      end
    end else if (!m_req_sent) begin
      if (mem_req_ready) m_req_sent = 1;
    end else if (!m_rsp_got) begin
      if (mem_rsp_valid) begin
        m_rsp_got = 1;
        m_data    = mem_rsp_data;
      end
    end else begin
      m_active = 0;
    end
  endtask

  task automatic check_outputs();
    bit rv;
    bit fv;
    rv = m_active && !m_req_sent;
    fv = m_active && m_rsp_got;
    expect_eq("miss_ready", miss_ready, !m_active);
    expect_eq("req_valid", mem_req_valid, rv);
    if (rv) expect_eq("req_addr", mem_req_addr, m_addr);
    expect_eq("fill_valid", fill_valid, fv);
    if (fv) begin
      expect_eq("fill_addr", fill_addr, m_addr);
      expect_eq("fill_data", fill_data, m_data);
      expect_eq("fill_prefetch", fill_prefetch, m_pf);
    end
    expect_eq("busy", busy, m_active || (m_q.size() != 0));
    expect_eq("drop_count", pf_drop_count, m_drop);
  endtask

  task automatic cycle(input logic mv, input logic [AW-1:0] ma, input logic pfe,
                       input logic rdy, input logic rv);
    @(negedge clk);
    miss_valid    = mv;
    miss_addr     = ma;
    pf_enable     = pfe;
    mem_req_ready = rdy;
    mem_rsp_valid = rv;
    mem_rsp_data  = rsp_word;
    if (mem_req_valid && rdy) req_log.push_back(mem_req_addr);
    if (fill_valid) fill_log.push_back('{fill_addr, fill_data, fill_prefetch});
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
  endtask

  task automatic drain(input int n);
    repeat (n) cycle(1'b0, '0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic send_miss(input logic [AW-1:0] a, input logic pfe);
    int n;
    n = 0;
    do begin
      cycle(1'b1, a, pfe, 1'b1, 1'b1);
      n++;
    end while (!m_accepted && n < 20);
    expect_eq("miss_accept_bound", m_accepted, 1);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset_n       = 1'b0;
    miss_valid    = 1'b0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    model_reset();
    expect_eq("rst_miss_ready", miss_ready, 0);
    expect_eq("rst_req_valid", mem_req_valid, 0);
    expect_eq("rst_req_addr", mem_req_addr, 0);
    expect_eq("rst_fill_valid", fill_valid, 0);
    expect_eq("rst_fill_addr", fill_addr, 0);
    expect_eq("rst_fill_data", fill_data, 0);
    expect_eq("rst_fill_pf", fill_prefetch, 0);
    expect_eq("rst_busy", busy, 0);
    expect_eq("rst_drop", pf_drop_count, 0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_outputs();
  endtask

  task automatic clear_logs();
    req_log.delete();
    fill_log.delete();
  endtask

  initial begin
    int n14;
    logic [AW-1:0] ra;
    model_reset();

    // Basic demand fill followed by its next-block prefetch.
    apply_reset();
    clear_logs();
    send_miss(8'h10, 1'b1);
    rsp_word = 32'hDEADBEEF;
    drain(3);
    rsp_word = 32'h11111111;
    drain(8);
    expect_eq("t1_req_count", req_log.size(), 2);
    if (req_log.size() >= 2) begin
      expect_eq("t1_req0", req_log[0], 8'h10);
      expect_eq("t1_req1", req_log[1], 8'h14);
    end
    expect_eq("t1_fill_count", fill_log.size(), 2);
    if (fill_log.size() >= 2) begin
      expect_eq("t1_fill0_addr", fill_log[0].a, 8'h10);
      expect_eq("t1_fill0_data", fill_log[0].d, 32'hDEADBEEF);
      expect_eq("t1_fill0_pf", fill_log[0].p, 0);
      expect_eq("t1_fill1_addr", fill_log[1].a, 8'h14);
      expect_eq("t1_fill1_data", fill_log[1].d, 32'h11111111);
      expect_eq("t1_fill1_pf", fill_log[1].p, 1);
    end
    expect_eq("t1_busy_after", busy, 0);

    // Unaligned miss and prefetch address wrap.
    clear_logs();
    cycle(1'b1, 8'h13, 1'b0, 1'b0, 1'b0);
    expect_eq("t2_req_valid", mem_req_valid, 1);
    expect_eq("t2_req_addr", mem_req_addr, 8'h10);
    drain(4);
    send_miss(8'hFC, 1'b1);
    drain(10);
    expect_eq("t2_req_count", req_log.size(), 3);
    if (req_log.size() >= 3) begin
      expect_eq("t2_req0", req_log[0], 8'h10);
      expect_eq("t2_req1", req_log[1], 8'hFC);
      expect_eq("t2_req2", req_log[2], 8'h00);
    end

    // Request held under back-pressure.
    clear_logs();
    cycle(1'b1, 8'h30, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 8'h70, 1'b0, 1'b0, 1'b0);
      expect_eq("t3_req_valid", mem_req_valid, 1);
      expect_eq("t3_req_addr", mem_req_addr, 8'h30);
      expect_eq("t3_miss_ready", miss_ready, 0);
    end
    expect_eq("t3_no_handshake", req_log.size(), 0);
    drain(5);
    expect_eq("t3_req_count", req_log.size(), 1);

    // FIFO overflow drops the third prefetch.
    apply_reset();
    clear_logs();
    send_miss(8'h20, 1'b1);
    send_miss(8'h40, 1'b1);
    send_miss(8'h60, 1'b1);
    expect_eq("t4_drop", pf_drop_count, 1);
    drain(30);
    expect_eq("t4_req_count", req_log.size(), 5);
    if (req_log.size() >= 5) begin
      expect_eq("t4_req3", req_log[3], 8'h24);
      expect_eq("t4_req4", req_log[4], 8'h44);
    end

    // Promotion of a queued prefetch to demand.
    apply_reset();
    clear_logs();
    send_miss(8'h10, 1'b1);
    send_miss(8'h14, 1'b1);
    drain(20);
    n14 = 0;
    foreach (req_log[i]) if (req_log[i] == 8'h14) n14++;
    expect_eq("t5_single_0x14", n14, 1);
    expect_eq("t5_req_count", req_log.size(), 3);
    if (fill_log.size() >= 3) begin
      expect_eq("t5_fill1_addr", fill_log[1].a, 8'h14);
      expect_eq("t5_fill1_pf", fill_log[1].p, 0);
      expect_eq("t5_fill2_addr", fill_log[2].a, 8'h18);
      expect_eq("t5_fill2_pf", fill_log[2].p, 1);
    end else begin
      expect_eq("t5_fill_count", fill_log.size(), 3);
    end

    // Reset in WAIT abandons the transaction; a stale response is ignored.
    apply_reset();
    clear_logs();
    send_miss(8'h50, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b0);
    apply_reset();
    clear_logs();
    repeat (4) cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    expect_eq("t6_no_fill", fill_log.size(), 0);
    expect_eq("t6_no_req", req_log.size(), 0);

    // Randomised traffic against the reference.
    apply_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        apply_reset();
      end else begin
        ra = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3) + 32'hE0);
        rsp_word = $urandom;
        cycle(($urandom_range(0, 2) == 0), ra, $urandom_range(0, 1) == 1,
              $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 4);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
